// File: rtl/dct_1d_mac_engine_if.sv
// Handshake/data bundle between the DCT transpose buffers and the 1-D MAC engine.
// The master drives vectors and consumes results; the slave is the engine.
interface dct_1d_mac_engine_if #(
    parameter int DATA_WIDTH = 32,
    parameter int POINTS     = 8
) ();
    logic                                  in_valid;
    logic                                  in_ready;
    logic [1:0]                            mode_sel;
    logic [DATA_WIDTH*POINTS-1:0]          data_in;
    logic [DATA_WIDTH*POINTS*POINTS-1:0]   coeff_vector;
    logic                                  out_valid;
    logic                                  out_ready;
    logic [DATA_WIDTH*POINTS-1:0]          dct_out;
    logic                                  sat_flag;
    logic                                  busy;

    modport master (
        output in_valid, mode_sel, data_in, coeff_vector, out_ready,
        input  in_ready, out_valid, dct_out, sat_flag, busy
    );

    modport slave (
        input  in_valid, mode_sel, data_in, coeff_vector, out_ready,
        output in_ready, out_valid, dct_out, sat_flag, busy
    );
endinterface

// File: rtl/dct_1d_mac_engine.sv
// N-point forward/inverse matrix transform (or bypass), one vector in flight.
// Each output lane owns a signed MAC; the column counter k walks the inputs
// so a full transform takes POINTS cycles, independent of mode.

// One output lane: accumulate C*x, then round half up, shift and clamp.
module dct_mac_lane #(
    parameter int DATA_WIDTH = 32,
    parameter int POINTS     = 8,
    parameter int FRAC_BITS  = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         clr,
    input  logic                         en,
    input  logic signed [DATA_WIDTH-1:0] coef,
    input  logic signed [DATA_WIDTH-1:0] x,
    output logic        [DATA_WIDTH-1:0] y_fin,
    output logic                         sat
);
    localparam int PW = 2 * DATA_WIDTH;
    localparam int AW = PW + $clog2(POINTS);
    // One spare bit so the rounding add can never wrap.
    localparam logic signed [AW:0] HALF = (AW+1)'(1) <<< (FRAC_BITS - 1);
    localparam logic signed [AW:0] MAXV = {{(AW-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [AW:0] MINV = {{(AW-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] acc_q, acc_next;
    logic signed [AW:0]   rnd, shifted;
    logic                 sat_hi, sat_lo;

    assign prod     = PW'(coef) * PW'(x);
    assign acc_next = acc_q + {{(AW-PW){prod[PW-1]}}, prod};

    // Finalisation works on acc_next so the last MAC step and the result
    // register land on the same clock edge.
    assign rnd     = {acc_next[AW-1], acc_next} + HALF;
    assign shifted = rnd >>> FRAC_BITS;
    assign sat_hi  = (shifted > MAXV);
    assign sat_lo  = (shifted < MINV);
    assign sat     = sat_hi | sat_lo;
    assign y_fin   = sat_hi ? MAXV[DATA_WIDTH-1:0] :
                     sat_lo ? MINV[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];

    // Accumulator: cleared on accept, one MAC per CALC cycle.
    always_ff @(posedge clk) begin
        if (!reset_n)  acc_q <= '0;
        else if (clr)  acc_q <= '0;
        else if (en)   acc_q <= acc_next;
    end
endmodule

module dct_1d_mac_engine #(
    parameter int DATA_WIDTH = 32,
    parameter int POINTS     = 8,
    parameter int FRAC_BITS  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    dct_1d_mac_engine_if.slave    bus
);
    localparam int KW = $clog2(POINTS);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t                                         state_q, state_d;
    logic [KW-1:0]                                  k_q;
    logic [1:0]                                     mode_q;
    logic [POINTS-1:0][DATA_WIDTH-1:0]              x_q, y_fin, dout_q;
    logic [POINTS-1:0][POINTS-1:0][DATA_WIDTH-1:0]  c_q;
    logic [POINTS-1:0]                              lane_sat;
    logic                                           sat_q;
    logic                                           accept, last_step, bypass, inverse, mac_en;

    assign accept    = bus.in_valid && (state_q == IDLE);
    assign last_step = (state_q == CALC) && (k_q == KW'(POINTS - 1));
    assign bypass    = mode_q[1];            // modes 2 and 3
    assign inverse   = (mode_q == 2'd1);
    assign mac_en    = (state_q == CALC) && !bypass;

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.dct_out   = dout_q;
    assign bus.sat_flag  = sat_q;

    // Next-state: accept -> CALC, last MAC -> DONE, output handshake -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)        state_d = CALC;
            CALC:    if (last_step)     state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Snapshot on accept, column counter during CALC, result capture on last step.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            k_q    <= '0;
            mode_q <= 2'd0;
            x_q    <= '0;
            c_q    <= '0;
            dout_q <= '0;
            sat_q  <= 1'b0;
        end else begin
            if (accept) begin
                k_q    <= '0;
                mode_q <= bus.mode_sel;
                x_q    <= bus.data_in;
                c_q    <= bus.coeff_vector;
            end else if (state_q == CALC) begin
                k_q <= k_q + 1'b1;
            end
            if (last_step) begin
                dout_q <= bypass ? x_q : y_fin;
                sat_q  <= bypass ? 1'b0 : |lane_sat;
            end
        end
    end

    for (genvar r = 0; r < POINTS; r++) begin : g_lane
        logic [DATA_WIDTH-1:0] coef;
        // Forward reads row r of C, inverse reads column r (transpose).
        assign coef = inverse ? c_q[k_q][r] : c_q[r][k_q];

        dct_mac_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .POINTS     (POINTS),
            .FRAC_BITS  (FRAC_BITS)
        ) u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .clr     (accept),
            .en      (mac_en),
            .coef    (coef),
            .x       (x_q[k_q]),
            .y_fin   (y_fin[r]),
            .sat     (lane_sat[r])
        );
    end
endmodule

// File: tb/tb_dct_1d_mac_engine.sv
// Scoreboard bench for dct_1d_mac_engine: directed vectors plus random traffic,
// expected results from a plain-arithmetic matrix model.
module tb_dct_1d_mac_engine;
    localparam int DW = 32;
    localparam int P  = 8;
    localparam int F  = 16;

    typedef struct {
        logic [P*DW-1:0] y;
        logic            sat;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    dct_1d_mac_engine_if #(.DATA_WIDTH(DW), .POINTS(P)) bus ();

    dct_1d_mac_engine #(.DATA_WIDTH(DW), .POINTS(P), .FRAC_BITS(F)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int   checks   = 0;
    int   failures = 0;
    exp_t q[$];

    logic signed [DW-1:0] cx [P];
    logic signed [DW-1:0] cc [P][P];
    logic [1:0]           cm;

    task automatic chk(input string nm, input logic [P*DW-1:0] act, input logic [P*DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic chk_i(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Reference: y = C*x (forward) or C^T*x (inverse), exact sum, round half up, clamp.
    function automatic exp_t model();
        exp_t e;
        logic signed [127:0] s, a, b, v;
        logic signed [127:0] maxv, minv;
        maxv = (128'sd1 <<< (DW-1)) - 128'sd1;
        minv = -(128'sd1 <<< (DW-1));
        e.y = '0;
        e.sat = 1'b0;
        for (int r = 0; r < P; r++) begin
            if (cm >= 2'd2) begin
                e.y[r*DW +: DW] = cx[r];
            end else begin
                s = '0;
                for (int k = 0; k < P; k++) begin
                    a = (cm == 2'd0) ? cc[r][k] : cc[k][r];
                    b = cx[k];
                    s = s + a * b;
                end
                v = (s + (128'sd1 <<< (F-1))) >>> F;
                if (v > maxv) begin v = maxv; e.sat = 1'b1; end
                else if (v < minv) begin v = minv; e.sat = 1'b1; end
                e.y[r*DW +: DW] = v[DW-1:0];
            end
        end
        return e;
    endfunction

    task automatic drive_cur();
        for (int i = 0; i < P; i++) bus.data_in[i*DW +: DW] = cx[i];
        for (int r = 0; r < P; r++)
            for (int c = 0; c < P; c++) bus.coeff_vector[(r*P+c)*DW +: DW] = cc[r][c];
        bus.mode_sel = cm;
    endtask

    task automatic scramble();
        for (int i = 0; i < P; i++) bus.data_in[i*DW +: DW] = $urandom;
        for (int j = 0; j < P*P; j++) bus.coeff_vector[j*DW +: DW] = $urandom;
        bus.mode_sel = 2'($urandom_range(0, 3));
    endtask

    task automatic set_c(input logic signed [DW-1:0] diag, input logic signed [DW-1:0] off);
        for (int r = 0; r < P; r++)
            for (int c = 0; c < P; c++) cc[r][c] = (r == c) ? diag : off;
    endtask

    // Wait for accept; returns at #1 after the accept edge.
    task automatic do_accept(output bit ok);
        ok = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        if (!ok) begin
            checks++; failures++;
            $display("FAIL accept_timeout in_ready never rose");
        end
    endtask

    // stall < 0: out_ready high from accept; otherwise hold out_ready low for stall cycles.
    task automatic run_txn(input int stall);
        bit ok, leak;
        int lat;
        logic [P*DW-1:0] held;
        logic held_sat;
        drive_cur();
        q.push_back(model());
        do_accept(ok);
        if (!ok) begin void'(q.pop_back()); return; end
        if (stall < 0) bus.out_ready = 1'b1;
        scramble();
        lat = 0;
        leak = 1'b0;
        while (!bus.out_valid && lat < 4*P) begin
            if (bus.in_ready || !bus.busy) leak = 1'b1;
            @(posedge clk); #1;
            lat++;
            scramble();
        end
        chk_i("latency", lat, P);
        chk_i("ready_low_in_calc", leak, 0);
        held = bus.dct_out;
        held_sat = bus.sat_flag;
        if (stall >= 0) begin
            for (int i = 0; i < stall; i++) begin
                @(posedge clk); #1;
                chk_i("stall_hold", (bus.dct_out == held && bus.sat_flag == held_sat &&
                                     bus.out_valid && !bus.in_ready), 1);
            end
            bus.out_ready = 1'b1;
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk_i("valid_drop", bus.out_valid, 0);
        chk_i("ready_rise", bus.in_ready, 1);
        chk("dout_kept", bus.dct_out, held);
    endtask

    // Monitor: compare every consumed result against the scoreboard head.
    always @(negedge clk) begin : mon
        exp_t e;
        if (reset_n && bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_result actual=%h expected=none", bus.dct_out);
            end else begin
                e = q.pop_front();
                chk("result", bus.dct_out, e.y);
                chk_i("sat_flag", bus.sat_flag, e.sat);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        bit ok;
        bit spurious;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.mode_sel = 2'd0;
        bus.data_in = '0;
        bus.coeff_vector = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_i("rst_in_ready", bus.in_ready, 1);
        chk_i("rst_out_valid", bus.out_valid, 0);
        chk_i("rst_busy", bus.busy, 0);
        chk_i("rst_sat", bus.sat_flag, 0);
        chk("rst_dout", bus.dct_out, '0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Identity
        set_c(32'sh0001_0000, 0);
        for (int i = 0; i < P; i++) cx[i] = i + 1;
        cm = 2'd0;
        run_txn(0);

        // All ones, x = 3, with a 5-cycle stall
        set_c(32'sh0001_0000, 32'sh0001_0000);
        for (int i = 0; i < P; i++) cx[i] = 3;
        run_txn(5);

        // Row 0 only: forward then inverse (transpose)
        set_c(0, 0);
        for (int c = 0; c < P; c++) cc[0][c] = 32'sh0001_0000;
        for (int i = 0; i < P; i++) cx[i] = i + 1;
        run_txn(-1);
        cm = 2'd1;
        run_txn(2);

        // Rounding with 0.5 diagonal
        set_c(32'sh0000_8000, 0);
        cx = '{1, -1, 3, -3, 0, 2, 5, -5};
        cm = 2'd0;
        run_txn(1);

        // Positive and negative saturation
        set_c(32'sh0001_0000, 32'sh0001_0000);
        for (int i = 0; i < P; i++) cx[i] = 32'sh7FFF_FFFF;
        run_txn(0);
        for (int i = 0; i < P; i++) cx[i] = 32'sh8000_0000;
        run_txn(-1);

        // Bypass and reserved mode, with large values that would clamp in MAC modes
        for (int i = 0; i < P; i++) cx[i] = $urandom;
        cm = 2'd2;
        run_txn(3);
        for (int i = 0; i < P; i++) cx[i] = $urandom;
        cm = 2'd3;
        run_txn(-1);

        // Reset in the middle of CALC: no result may appear
        set_c(32'sh0001_0000, 32'sh0001_0000);
        for (int i = 0; i < P; i++) cx[i] = 32'sh7FFF_FFFF;
        cm = 2'd0;
        drive_cur();
        do_accept(ok);
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        chk_i("midrst_out_valid", bus.out_valid, 0);
        chk_i("midrst_in_ready", bus.in_ready, 1);
        chk("midrst_dout", bus.dct_out, '0);
        chk_i("midrst_sat", bus.sat_flag, 0);
        chk_i("midrst_busy", bus.busy, 0);
        spurious = 1'b0;
        for (int i = 0; i < P + 2; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) spurious = 1'b1;
        end
        bus.out_ready = 1'b0;
        chk_i("midrst_no_result", spurious, 0);

        // Fresh vector after reset: accumulators must start from zero
        set_c(32'sh0001_0000, 0);
        for (int i = 0; i < P; i++) cx[i] = 10 * (i + 1);
        run_txn(0);

        // Random traffic across all modes
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < P; i++)
                cx[i] = (t % 3 == 0) ? DW'($urandom) : DW'($signed(32'($urandom_range(0, 2000))) - 1000);
            for (int r = 0; r < P; r++)
                for (int c = 0; c < P; c++)
                    cc[r][c] = (t % 4 == 1) ? DW'($urandom)
                                            : DW'($signed(32'($urandom_range(0, 32'h0002_0000))) - 32'sh0001_0000);
            cm = 2'($urandom_range(0, 3));
            run_txn($signed($urandom_range(0, 5)) - 1);
        end

        repeat (3) @(posedge clk);
        #1;
        chk_i("scoreboard_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
